rx_driver: RTL and testbench

RX_DRIVER -- requirements
Module: rx_driver

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_driver_if.sv | 16 +
 rtl/rx_msg_buffer.sv | 20 ++
 rtl/rx_driver.sv | 130 +++++++++++++
 tb/tb_rx_driver.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants.
package uart_pkg;

  // Receive-driver FSM states; LISTEN is the idle/armed state.
  typedef enum logic [1:0] {
    LISTEN = 2'd0,
    HOLD   = 2'd1,
    DONE   = 2'd2
  } rx_state_t;

  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam int         DEFAULT_MSG_DEPTH = 64;

endpackage

// File: rtl/rx_driver_if.sv
// Message-buffer bus: one write port plus one combinational read port.
interface rx_driver_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;

  // Master owns the address/data lines; slave is the storage array.
  modport master (output we, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input we, input waddr, input wdata, input raddr, output rdata);
endinterface

// File: rtl/rx_msg_buffer.sv
// DEPTH x 8 message store: synchronous write, asynchronous read, no reset.
module rx_msg_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  rx_driver_if.slave  bus
);

  logic [7:0] mem [DEPTH];

  // Write port: one byte per edge when enabled.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.rdata = mem[bus.raddr];

endmodule

// File: rtl/rx_driver.sv
// Captures UART bytes into a message buffer until the terminator or a full
// buffer, acknowledging each byte with a one-cycle RxRead pulse.
module rx_driver
  import uart_pkg::*;
#(
  parameter int         DEPTH = DEFAULT_MSG_DEPTH,
  parameter logic [7:0] TERM  = ASCII_CR
) (
  input  logic                       Enable,
  input  logic                       Reset,
  input  logic                       RxReady,
  input  logic [7:0]                 RxData,
  input  logic                       Clear,
  input  logic [$clog2(DEPTH)-1:0]   RdAddr,
  output logic                       RxRead,
  output logic [7:0]                 RdData,
  output logic [$clog2(DEPTH+1)-1:0] ByteCount,
  output logic                       MsgDone,
  output logic                       Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;
  logic          rx_read_q, rx_read_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  // Set while a dropped byte is still presented in DONE, so it is acked once.
  logic          drop_busy_q, drop_busy_d;
  logic          wr_en;

  rx_driver_if #(.DEPTH(DEPTH)) buf_bus ();

  rx_msg_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk (Enable),
    .bus (buf_bus)
  );

  assign buf_bus.we    = wr_en;
  assign buf_bus.waddr = count_q[AW-1:0];
  assign buf_bus.wdata = RxData;
  assign buf_bus.raddr = RdAddr;
  assign RdData        = buf_bus.rdata;

  // Next-state and buffer-write decode; Clear outranks any incoming byte.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    rx_read_d   = 1'b0;
    done_d      = done_q;
    ovf_d       = ovf_q;
    drop_busy_d = drop_busy_q;
    wr_en       = 1'b0;

    if (Clear) begin
      state_d     = LISTEN;
      count_d     = '0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      drop_busy_d = 1'b0;
    end else begin
      case (state_q)
        LISTEN: begin
          // The count guard keeps the write address in range even if state
          // were ever inconsistent; normally a full buffer already sits in DONE.
          if (RxReady && (count_q < DEPTH_C)) begin
            wr_en     = ~Reset;
            count_d   = count_q + CW'(1);
            rx_read_d = 1'b1;
            last_d    = (RxData == TERM) || ((count_q + CW'(1)) == DEPTH_C);
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (!RxReady) begin
            if (last_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = LISTEN;
            end
          end
        end
        DONE: begin
          if (!RxReady) begin
            drop_busy_d = 1'b0;
          end else if (!drop_busy_q) begin
            rx_read_d   = 1'b1;
            ovf_d       = 1'b1;
            drop_busy_d = 1'b1;
          end
        end
        default: state_d = LISTEN;
      endcase
    end
  end

  // State register; Reset overrides Clear and RxReady.
  always_ff @(posedge Enable) begin
    if (Reset) begin
      state_q     <= LISTEN;
      count_q     <= '0;
      last_q      <= 1'b0;
      rx_read_q   <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      rx_read_q   <= rx_read_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      drop_busy_q <= drop_busy_d;
    end
  end

  assign RxRead    = rx_read_q;
  assign ByteCount = count_q;
  assign MsgDone   = done_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_rx_driver.sv
// Bench for rx_driver: a 64-deep and a 4-deep instance share data/Clear/Reset.
module tb_rx_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [7:0] data;
  logic       ready, ready4;

  logic       rx_read, rx_read4;
  logic [6:0] count;
  logic [2:0] count4;
  logic       done, done4, ovf, ovf4;
  logic [1:0] rd_addr4;
  logic [7:0] rd_data4;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q4[$];

  rx_driver_if #(.DEPTH(64)) bus ();
  assign bus.we    = 1'b0;
  assign bus.waddr = '0;
  assign bus.wdata = '0;

  always #5 clk = ~clk;

  rx_driver #(.DEPTH(64), .TERM(8'h0D)) dut (
    .Enable(clk), .Reset(rst), .RxReady(ready), .RxData(data), .Clear(clear),
    .RdAddr(bus.raddr), .RxRead(rx_read), .RdData(bus.rdata), .ByteCount(count),
    .MsgDone(done), .Overflow(ovf)
  );

  rx_driver #(.DEPTH(4), .TERM(8'h0D)) dut4 (
    .Enable(clk), .Reset(rst), .RxReady(ready4), .RxData(data), .Clear(clear),
    .RdAddr(rd_addr4), .RxRead(rx_read4), .RdData(rd_data4), .ByteCount(count4),
    .MsgDone(done4), .Overflow(ovf4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte, wait (bounded) for the ack, drop RxReady one cycle later.
  task automatic send_byte(input bit sel, input logic [7:0] b, output bit acked);
    acked = 1'b0;
    @(negedge clk);
    data = b;
    if (sel) ready4 = 1'b1; else ready = 1'b1;
    for (int i = 0; i < 10 && !acked; i++) begin
      @(posedge clk); #1;
      if ((sel ? rx_read4 : rx_read) === 1'b1) acked = 1'b1;
    end
    @(negedge clk);
    ready = 1'b0;
    ready4 = 1'b0;
    @(posedge clk); #1;
    $display("[TB] dut%0s byte %h acked=%0d", sel ? "4" : "64", b, acked);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; ready = 1'b0; ready4 = 1'b0; data = 8'h00;
    bus.raddr = '0; rd_addr4 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({rx_read, count, done, ovf} !== 10'd0) begin
      tests_failed++; $display("FAIL reset64 got %b want 0", {rx_read, count, done, ovf});
    end
    tests_run++;
    if ({rx_read4, count4, done4, ovf4} !== 6'd0) begin
      tests_failed++; $display("FAIL reset4 got %b want 0", {rx_read4, count4, done4, ovf4});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_hello();
    logic [7:0] msg [6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
    bit ack;
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b0, msg[i], ack);
      exp_q.push_back(msg[i]);
      tests_run++;
      if (ack !== 1'b1) begin tests_failed++; $display("FAIL hello_ack[%0d] got %0d want 1", i, ack); end
      if (i == 4) begin
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL hello_early_done got %b want 0", done); end
      end
    end
    tests_run++;
    if (count !== 7'd6) begin tests_failed++; $display("FAIL hello_count got %0d want 6", count); end
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL hello_done got %b want 1", done); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL hello_ovf got %b want 0", ovf); end
    for (int a = 0; exp_q.size() > 0; a++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      bus.raddr = 6'(a); #1;
      tests_run++;
      if (bus.rdata !== e) begin tests_failed++; $display("FAIL hello_mem[%0d] got %h want %h", a, bus.rdata, e); end
    end
  endtask

  task automatic test_hold_long();
    int pulses;
    pulse_clear();
    pulses = 0;
    @(negedge clk); data = 8'h41; ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (rx_read === 1'b1) pulses++; end
    @(negedge clk); ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rx_read === 1'b1) pulses++; end
    $display("[TB] dut64 byte 41 held 5 cycles, pulses=%0d", pulses);
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    tests_run++;
    if (count !== 7'd1) begin tests_failed++; $display("FAIL hold_count got %0d want 1", count); end
  endtask

  task automatic test_depth_full();
    logic [7:0] msg [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    bit ack;
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, msg[i], ack);
      if (i < 4) exp_q4.push_back(msg[i]);
      tests_run++;
      if (ack !== 1'b1) begin tests_failed++; $display("FAIL depth_ack[%0d] got %0d want 1", i, ack); end
      if (i == 2) begin
        tests_run++;
        if (done4 !== 1'b0) begin tests_failed++; $display("FAIL depth_early_done got %b want 0", done4); end
      end
      if (i == 3) begin
        tests_run++;
        if ({done4, ovf4, count4} !== {1'b1, 1'b0, 3'd4}) begin
          tests_failed++; $display("FAIL depth_full got done=%b ovf=%b cnt=%0d want 1 0 4", done4, ovf4, count4);
        end
      end
    end
    tests_run++;
    if ({done4, ovf4, count4} !== {1'b1, 1'b1, 3'd4}) begin
      tests_failed++; $display("FAIL depth_overflow got done=%b ovf=%b cnt=%0d want 1 1 4", done4, ovf4, count4);
    end
    for (int a = 0; exp_q4.size() > 0; a++) begin
      logic [7:0] e;
      e = exp_q4.pop_front();
      rd_addr4 = 2'(a); #1;
      tests_run++;
      if (rd_data4 !== e) begin tests_failed++; $display("FAIL depth_mem[%0d] got %h want %h", a, rd_data4, e); end
    end
  endtask

  task automatic test_clear_reuse();
    logic [7:0] hi [4] = '{8'h48, 8'h49, 8'h0D, 8'h21};
    logic [7:0] ok [3] = '{8'h4F, 8'h4B, 8'h0D};
    bit ack;
    pulse_clear();
    for (int i = 0; i < 4; i++) send_byte(1'b0, hi[i], ack);
    tests_run++;
    if ({done, ovf} !== 2'b11) begin tests_failed++; $display("FAIL reuse_pre got done/ovf=%b want 11", {done, ovf}); end
    pulse_clear();
    tests_run++;
    if ({count, done, ovf} !== 9'd0) begin tests_failed++; $display("FAIL reuse_cleared got %b want 0", {count, done, ovf}); end
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b0, ok[i], ack);
      exp_q.push_back(ok[i]);
    end
    tests_run++;
    if ({count, done, ovf} !== {7'd3, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL reuse_after got cnt=%0d done=%b ovf=%b want 3 1 0", count, done, ovf);
    end
    bus.raddr = '0; #1;
    tests_run++;
    if (bus.rdata !== exp_q[0]) begin tests_failed++; $display("FAIL reuse_mem0 got %h want %h", bus.rdata, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_clear_priority();
    bit ack;
    @(negedge clk); clear = 1'b1; ready = 1'b1; data = 8'h58;
    @(posedge clk); #1;
    tests_run++;
    if ({rx_read, count} !== 8'd0) begin
      tests_failed++; $display("FAIL clrprio_same got rxread=%b cnt=%0d want 0 0", rx_read, count);
    end
    @(negedge clk); clear = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 10 && !ack; i++) begin @(posedge clk); #1; if (rx_read === 1'b1) ack = 1'b1; end
    @(negedge clk); ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'h58);
    $display("[TB] dut64 byte 58 after Clear acked=%0d", ack);
    tests_run++;
    if ({ack, count} !== {1'b1, 7'd1}) begin
      tests_failed++; $display("FAIL clrprio_after got ack=%0d cnt=%0d want 1 1", ack, count);
    end
    bus.raddr = '0; #1;
    tests_run++;
    if (bus.rdata !== exp_q.pop_front()) begin tests_failed++; $display("FAIL clrprio_mem0 got %h want 58", bus.rdata); end
  endtask

  task automatic test_reset_hold();
    bit ack;
    pulse_clear();
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h30 + 8'(i), ack);
    @(negedge clk); data = 8'h5A; ready = 1'b1;
    ack = 1'b0;
    for (int i = 0; i < 10 && !ack; i++) begin @(posedge clk); #1; if (rx_read === 1'b1) ack = 1'b1; end
    tests_run++;
    if ({ack, count} !== {1'b1, 7'd4}) begin tests_failed++; $display("FAIL rsthold_pre got ack=%0d cnt=%0d want 1 4", ack, count); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({rx_read, count, done, ovf} !== 10'd0) begin
      tests_failed++; $display("FAIL rsthold_outputs got %b want 0", {rx_read, count, done, ovf});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (rx_read !== 1'b1) begin tests_failed++; $display("FAIL rsthold_recapture got %b want 1", rx_read); end
    @(negedge clk); ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(8'h5A);
    $display("[TB] dut64 byte 5a recaptured after Reset");
    tests_run++;
    if (count !== 7'd1) begin tests_failed++; $display("FAIL rsthold_count got %0d want 1", count); end
    bus.raddr = '0; #1;
    tests_run++;
    if (bus.rdata !== exp_q.pop_front()) begin tests_failed++; $display("FAIL rsthold_mem0 got %h want 5a", bus.rdata); end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_hold_long();
    test_depth_full();
    test_clear_reuse();
    test_clear_priority();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
